// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the wait-stated data-memory responder.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Read data returned for a misaligned read.
  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // An access is in error when it is misaligned or asks for read and write at once.
  function automatic logic acc_err(input logic ren, input logic wen, input logic [1:0] lsb);
    return (ren & wen) | (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_resp_word_ram.sv
// Word-wide storage: synchronous write, asynchronous read, no reset.
module word_ram #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  // Array update; contents are left undefined until first written.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: IDLE -> WAIT x WAIT_CYCLES -> RESP, stalling the CPU meanwhile.
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  cap_ren_q, cap_wen_q;
  logic [ADDR_WIDTH+1:0] cap_addr_q;
  logic [31:0]           cap_wdata_q;
  logic [31:0]           din_q;
  logic                  err_q;
  logic [15:0]           rd_cnt_q, wr_cnt_q;

  logic                  req, enter_resp, from_idle;
  logic                  acc_ren, acc_wen, acc_bad, acc_rd_ok, acc_wr_ok;
  logic [ADDR_WIDTH+1:0] acc_addr;
  logic [31:0]           acc_wdata, ram_rdata;

  // Address bits above the array span are ignored (addresses wrap).
  logic unused_addr_hi;
  assign unused_addr_hi = ^mem_addr[31:ADDR_WIDTH+2];

  assign req = mem_ren | mem_wen;

  // With zero wait states the access completes straight out of IDLE, before
  // the capture registers are loaded, so the live inputs are used there.
  assign from_idle = (state_q == IDLE);
  assign acc_ren   = from_idle ? mem_ren : cap_ren_q;
  assign acc_wen   = from_idle ? mem_wen : cap_wen_q;
  assign acc_addr  = from_idle ? mem_addr[ADDR_WIDTH+1:0] : cap_addr_q;
  assign acc_wdata = from_idle ? mem_dout : cap_wdata_q;
  assign acc_bad   = acc_err(acc_ren, acc_wen, acc_addr[1:0]);
  assign acc_rd_ok = acc_ren & ~acc_bad;
  assign acc_wr_ok = acc_wen & ~acc_bad;

  word_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i  (clk),
    .we_i   (enter_resp & acc_wr_ok),
    .addr_i (acc_addr[ADDR_WIDTH+1:2]),
    .wdata_i(acc_wdata),
    .rdata_o(ram_rdata)
  );

  // Next-state, wait counter and stall.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    enter_resp = 1'b0;
    mem_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          mem_stall = 1'b1;
          wcnt_d    = 4'd0;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (wcnt_q == WAIT_LAST) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          wcnt_d     = 4'd0;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RESP:    state_d = IDLE;  // held request is the one just served
      default: state_d = IDLE;
    endcase
  end

  // State register and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      cap_ren_q   <= 1'b0;
      cap_wen_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (from_idle && req) begin
        cap_ren_q   <= mem_ren;
        cap_wen_q   <= mem_wen;
        cap_addr_q  <= mem_addr[ADDR_WIDTH+1:0];
        cap_wdata_q <= mem_dout;
      end
    end
  end

  // Completion side effects, all on the edge entering RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q    <= '0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q <= enter_resp & acc_bad;
      if (enter_resp && acc_ren && !acc_wen)
        din_q <= (acc_addr[1:0] != 2'b00) ? MEM_ERR_DATA : ram_rdata;
      if (enter_resp && acc_rd_ok && rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (enter_resp && acc_wr_ok && wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign mem_din = din_q;
  assign mem_err = err_q;
  assign rd_cnt  = rd_cnt_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: a 2-wait-state instance and a 0-wait-state instance.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren, wen, stall, err_w;
  logic [31:0] addr, wdata, din_w;
  logic [15:0] rdc, wrc;
  logic        ren0, wen0, stall0, err0;
  logic [31:0] addr0, wdata0, din0;
  logic [15:0] rdc0, wrc0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model of the 2-wait-state instance
  logic [31:0] mdl_mem [256];
  logic [31:0] mdin = 32'h0;
  logic [15:0] mrd = 16'h0, mwr = 16'h0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dmem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren), .mem_wen(wen), .mem_addr(addr),
    .mem_dout(wdata), .mem_din(din_w), .mem_stall(stall), .mem_err(err_w),
    .rd_cnt(rdc), .wr_cnt(wrc)
  );

  dmem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mem_ren(ren0), .mem_wen(wen0), .mem_addr(addr0),
    .mem_dout(wdata0), .mem_din(din0), .mem_stall(stall0), .mem_err(err0),
    .rd_cnt(rdc0), .wr_cnt(wrc0)
  );

  // model: apply one access, return the mem_din expected afterwards
  function automatic logic [31:0] mdl(input logic r, input logic w, input logic [31:0] a,
                                      input logic [31:0] d);
    int idx;
    idx = int'(a[9:2]);
    if (r && w) begin
    end else if (w) begin
      if (a[1:0] == 2'b00) begin
        mdl_mem[idx] = d;
        if (mwr != 16'hFFFF) mwr++;
      end
    end else if (r) begin
      if (a[1:0] != 2'b00) mdin = 32'hDEADBEEF;
      else begin
        mdin = mdl_mem[idx];
        if (mrd != 16'hFFFF) mrd++;
      end
    end
    return mdin;
  endfunction

  // drive one request at a negedge, hold it until the RESP cycle, sample there
  task automatic access(input bit z, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int nst, output logic [31:0] din,
                        output logic err);
    @(negedge clk);
    if (z) begin ren0 = r; wen0 = w; addr0 = a; wdata0 = d; end
    else   begin ren  = r; wen  = w; addr  = a; wdata  = d; end
    nst = 0;
    #1;
    while ((z ? stall0 : stall) === 1'b1 && nst < 40) begin
      nst++;
      @(negedge clk);
      #1;
    end
    din = z ? din0 : din_w;
    err = z ? err0 : err_w;
  endtask

  task automatic idle();
    @(negedge clk);
    ren = 0; wen = 0; ren0 = 0; wen0 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ren = 0; wen = 0; addr = 0; wdata = 0;
    ren0 = 0; wen0 = 0; addr0 = 0; wdata0 = 0;
    #12;
    n_cmp++; if (din_w !== 32'h0) begin n_bad++; $display("FAIL rst_din got %h exp 0", din_w); end
    n_cmp++; if (err_w !== 1'b0) begin n_bad++; $display("FAIL rst_err got %b exp 0", err_w); end
    n_cmp++; if (rdc !== 16'h0 || wrc !== 16'h0) begin n_bad++; $display("FAIL rst_cnt got %h/%h exp 0/0", rdc, wrc); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_idle got %b exp 0", stall); end
    ren = 1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall_req got %b exp 1", stall); end
    ren = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int nst; logic [31:0] d; logic e;
    void'(mdl(1'b0, 1'b1, 32'h10, 32'h12345678));
    access(0, 1'b0, 1'b1, 32'h10, 32'h12345678, nst, d, e);
    n_cmp++; if (nst !== 3) begin n_bad++; $display("FAIL wr_stall got %0d exp 3", nst); end
    n_cmp++; if (wrc !== 16'd1) begin n_bad++; $display("FAIL wr_cnt got %0d exp 1", wrc); end
    n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL wr_err got %b exp 0", e); end
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h10, 32'h0));
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL rd_data got %h exp 12345678", d); end
    n_cmp++; if (nst !== 3) begin n_bad++; $display("FAIL rd_stall got %0d exp 3", nst); end
    n_cmp++; if (rdc !== 16'd1) begin n_bad++; $display("FAIL rd_cnt got %0d exp 1", rdc); end
    idle();
  endtask

  task automatic test_back_to_back();
    int nst; logic [31:0] d; logic e;
    void'(mdl(1'b0, 1'b1, 32'h4, 32'hA5A5A5A5));
    access(0, 1'b0, 1'b1, 32'h4, 32'hA5A5A5A5, nst, d, e);
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h4, 32'h0));
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL b2b_data got %h exp a5a5a5a5", d); end
    n_cmp++; if (nst !== 3) begin n_bad++; $display("FAIL b2b_stall got %0d exp 3", nst); end
    idle();
  endtask

  task automatic test_errors();
    int nst; logic [31:0] d; logic e;
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h6, 32'h0));
    access(0, 1'b1, 1'b0, 32'h6, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL mis_data got %h exp deadbeef", d); end
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL mis_err got %b exp 1", e); end
    n_cmp++; if (rdc !== mrd) begin n_bad++; $display("FAIL mis_rdcnt got %0d exp %0d", rdc, mrd); end
    idle(); #1;
    n_cmp++; if (err_w !== 1'b0) begin n_bad++; $display("FAIL mis_err_width got %b exp 0", err_w); end
    exp_q.push_back(mdl(1'b1, 1'b1, 32'h10, 32'h0BAD0BAD));
    access(0, 1'b1, 1'b1, 32'h10, 32'h0BAD0BAD, nst, d, e);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL both_err got %b exp 1", e); end
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL both_din got %h exp deadbeef", d); end
    n_cmp++; if (wrc !== mwr) begin n_bad++; $display("FAIL both_wrcnt got %0d exp %0d", wrc, mwr); end
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h10, 32'h0));
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL both_nowrite got %h exp 12345678", d); end
    idle();
  endtask

  task automatic test_wrap();
    int nst; logic [31:0] d; logic e;
    void'(mdl(1'b0, 1'b1, 32'h400, 32'h1));
    access(0, 1'b0, 1'b1, 32'h400, 32'h1, nst, d, e);
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h0, 32'h0));
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL wrap_data got %h exp 1", d); end
    idle();
  endtask

  task automatic test_random();
    int nst; logic [31:0] d, a, v, x; logic e, r;
    for (int i = 0; i < 8; i++) begin
      a = 32'h40 + 32'(i * 4); v = $urandom;
      void'(mdl(1'b0, 1'b1, a, v));
      access(0, 1'b0, 1'b1, a, v, nst, d, e);
    end
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom_range(0, 1));
      a = 32'h40 + 32'($urandom_range(0, 7) * 4); v = $urandom;
      x = mdl(r, ~r, a, v);
      if (r) exp_q.push_back(x);
      access(0, r, ~r, a, v, nst, d, e);
      if (r) begin
        x = exp_q.pop_front();
        n_cmp++; if (d !== x) begin n_bad++; $display("FAIL rnd_rd[%0d] got %h exp %h", i, d, x); end
      end
    end
    idle(); #1;
    n_cmp++; if (rdc !== mrd || wrc !== mwr) begin n_bad++; $display("FAIL rnd_cnt got %0d/%0d exp %0d/%0d", rdc, wrc, mrd, mwr); end
  endtask

  task automatic test_reset_mid_wait();
    int nst; logic [31:0] d; logic e;
    void'(mdl(1'b0, 1'b1, 32'h8, 32'h11));
    access(0, 1'b0, 1'b1, 32'h8, 32'h11, nst, d, e);
    idle();
    @(negedge clk);
    wen = 1; addr = 32'h8; wdata = 32'hFF;
    @(negedge clk);          // first WAIT cycle
    wen = 0; rst_n = 1'b0; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rstw_stall got %b exp 0", stall); end
    n_cmp++; if (wrc !== 16'd0) begin n_bad++; $display("FAIL rstw_wrcnt got %0d exp 0", wrc); end
    @(negedge clk);
    rst_n = 1'b1;
    mwr = 0; mrd = 0; mdin = 0;
    exp_q.push_back(mdl(1'b1, 1'b0, 32'h8, 32'h0));
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, nst, d, e);
    n_cmp++; if (d !== exp_q.pop_front()) begin n_bad++; $display("FAIL rstw_keep got %h exp 11", d); end
    n_cmp++; if (nst !== 3) begin n_bad++; $display("FAIL rstw_restart got %0d exp 3", nst); end
    idle();
  endtask

  task automatic test_zero_wait();
    int nst; logic [31:0] d; logic e;
    access(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, nst, d, e);
    n_cmp++; if (nst !== 1) begin n_bad++; $display("FAIL z_wr_stall got %0d exp 1", nst); end
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, nst, d, e);
    n_cmp++; if (nst !== 1) begin n_bad++; $display("FAIL z_rd_stall got %0d exp 1", nst); end
    n_cmp++; if (d !== 32'hCAFEF00D) begin n_bad++; $display("FAIL z_rd_data got %h exp cafef00d", d); end
    n_cmp++; if (rdc0 !== 16'd1 || wrc0 !== 16'd1) begin n_bad++; $display("FAIL z_cnt got %0d/%0d exp 1/1", rdc0, wrc0); end
    access(1, 1'b1, 1'b0, 32'h21, 32'h0, nst, d, e);
    n_cmp++; if (e !== 1'b1 || d !== 32'hDEADBEEF) begin n_bad++; $display("FAIL z_mis got %b/%h exp 1/deadbeef", e, d); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_errors();
    test_wrap();
    test_random();
    test_reset_mid_wait();
    test_zero_wait();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, word-address bits, giving 2^ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access, legal range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_ren  input  1  read request from the CPU MEM stage.
REQ-006 SHALL have port mem_wen  input  1  write request from the CPU MEM stage.
REQ-007 SHALL have port mem_addr  input  32  byte address of the request.
REQ-008 SHALL have port mem_dout  input  32  write data from the CPU.
REQ-009 SHALL have port mem_din  output  32  read data to the CPU, registered.
REQ-010 SHALL have port mem_stall  output  1  CPU pipeline freeze while an access is outstanding.
REQ-011 SHALL have port mem_err  output  1  one-cycle error pulse coincident with response.
REQ-012 SHALL have ports rd_cnt and wr_cnt  output  16 each  completed-access counters.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 In IDLE, req = mem_ren|mem_wen; on req SHALL latch addr, wdata, type into capture registers and go to WAIT, or to RESP directly if WAIT_CYCLES=0.
REQ-015 In WAIT, SHALL count wait cycles from 0 and go to RESP after exactly WAIT_CYCLES cycles in WAIT.
REQ-016 In RESP, SHALL return to IDLE unconditionally after one cycle; requests seen in RESP are ignored, being the same held request.
REQ-017 mem_stall SHALL be combinational: 1 in IDLE while req=1, 1 throughout WAIT, 0 in RESP and in idle IDLE.
REQ-018 Total request-to-RESP latency SHALL be WAIT_CYCLES+1 cycles; the CPU sees stall for exactly WAIT_CYCLES+1 cycles.
REQ-019 Word index SHALL be captured addr[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 2^(ADDR_WIDTH+2).
REQ-020 Writes SHALL update the array on the clock edge entering RESP; reads SHALL load mem_din on that same edge.
REQ-021 mem_din SHALL hold its value until the next read completes; writes SHALL not alter mem_din.
REQ-022 A request with addr[1:0]!=0 (misaligned) SHALL run full timing, perform no write, load mem_din with 32'hDEADBEEF if a read, and pulse mem_err in RESP.
REQ-023 A request with mem_ren and mem_wen both 1 SHALL be treated as an error: no write, mem_din unchanged, mem_err pulses in RESP.
REQ-024 rd_cnt and wr_cnt SHALL increment on successful, error-free read and write completion respectively, saturating at 16'hFFFF.
REQ-025 A read of a word written by the immediately preceding access SHALL return the new data, with no bypass hazard.

Reset
REQ-026 While rst_n=0: state=IDLE, wait counter=0, mem_din=0, mem_err=0, rd_cnt=wr_cnt=0, capture registers=0; mem_stall SHALL follow REQ-017 from IDLE.
REQ-027 Reset asserted before the edge entering RESP SHALL abort the access; no array write occurs and no counter changes.
REQ-028 Array contents SHALL not be reset; they are undefined until written.

Structure
REQ-029 State encodings (IDLE=0, WAIT=1, RESP=2) and MEM_ERR_DATA=32'hDEADBEEF SHALL live in the shared define header.
REQ-030 Storage SHALL be a sub-module word_ram: synchronous write, asynchronous read, parameterised by ADDR_WIDTH; all control SHALL stay in dmem_resp.

Verification
REQ-031 Write with WAIT_CYCLES=2: wen, addr 0x10, data 0x12345678 -> stall is high for 3 cycles, wr_cnt=1; a later read of 0x10 -> mem_din=0x12345678 on the RESP cycle, rd_cnt=1.
REQ-032 Back-to-back accesses: write 0x4=0xA5A5A5A5, then read 0x4 in the very next free cycle -> mem_din=0xA5A5A5A5 with no extra stall gap.
REQ-033 Errors: read of 0x6 -> mem_din=0xDEADBEEF, mem_err=1 for 1 cycle, rd_cnt unchanged; ren=wen=1 -> mem_err pulse and no write.
REQ-034 Wrap: write 0x400=0x1 with ADDR_WIDTH=8 -> a read of 0x0 returns 0x1.
REQ-035 Reset mid-WAIT: write 0x8=0xFF, then rst_n low during the WAIT cycle -> state IDLE, stall 0, word 0x8 retains its prior value, wr_cnt=0.
REQ-036 WAIT_CYCLES=0: read -> stall is high for exactly 1 cycle and data arrives in the next cycle.
